// File: rtl/ysyx_24110006_arbiter.sv
// Two-master AXI read arbiter: IFU and LSU share one upstream read port, LSU writes pass through.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise LSU wins every tie.
module ysyx_24110006_arbiter (
  input  logic        i_clock,
  input  logic        i_reset,
  // ifu read requester
  input  logic [31:0] ifu_araddr,
  input  logic [3:0]  ifu_arid,
  input  logic [7:0]  ifu_arlen,
  input  logic [2:0]  ifu_arsize,
  input  logic [1:0]  ifu_arburst,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  output logic [31:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,
  output logic [3:0]  ifu_rid,
  output logic        ifu_rlast,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,
  // lsu read requester
  input  logic [31:0] lsu_araddr,
  input  logic [3:0]  lsu_arid,
  input  logic [7:0]  lsu_arlen,
  input  logic [2:0]  lsu_arsize,
  input  logic [1:0]  lsu_arburst,
  input  logic        lsu_arvalid,
  output logic        lsu_arready,
  output logic [31:0] lsu_rdata,
  output logic [1:0]  lsu_rresp,
  output logic [3:0]  lsu_rid,
  output logic        lsu_rlast,
  output logic        lsu_rvalid,
  input  logic        lsu_rready,
  // lsu write channels
  input  logic [31:0] lsu_awaddr,
  input  logic [3:0]  lsu_awid,
  input  logic [7:0]  lsu_awlen,
  input  logic [2:0]  lsu_awsize,
  input  logic [1:0]  lsu_awburst,
  input  logic        lsu_awvalid,
  output logic        lsu_awready,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  input  logic        lsu_wlast,
  input  logic        lsu_wvalid,
  output logic        lsu_wready,
  output logic [1:0]  lsu_bresp,
  output logic [3:0]  lsu_bid,
  output logic        lsu_bvalid,
  input  logic        lsu_bready,
  // upstream master port
  output logic [31:0] out_araddr,
  output logic [3:0]  out_arid,
  output logic [7:0]  out_arlen,
  output logic [2:0]  out_arsize,
  output logic [1:0]  out_arburst,
  output logic        out_arvalid,
  input  logic        out_arready,
  input  logic [31:0] out_rdata,
  input  logic [1:0]  out_rresp,
  input  logic [3:0]  out_rid,
  input  logic        out_rlast,
  input  logic        out_rvalid,
  output logic        out_rready,
  output logic [31:0] out_awaddr,
  output logic [3:0]  out_awid,
  output logic [7:0]  out_awlen,
  output logic [2:0]  out_awsize,
  output logic [1:0]  out_awburst,
  output logic        out_awvalid,
  input  logic        out_awready,
  output logic [31:0] out_wdata,
  output logic [3:0]  out_wstrb,
  output logic        out_wlast,
  output logic        out_wvalid,
  input  logic        out_wready,
  input  logic [1:0]  out_bresp,
  input  logic [3:0]  out_bid,
  input  logic        out_bvalid,
  output logic        out_bready
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;
  typedef enum logic {GNT_IFU, GNT_LSU} gnt_e;

  state_e state_q, state_d;
  gnt_e   gnt_q, gnt_d;
  gnt_e   last_q, last_d;
  gnt_e   tie_gnt;
  logic   sel_arvalid;
  logic   sel_rready;

`ifdef ARB_RR_EN
  assign tie_gnt = (last_q == GNT_IFU) ? GNT_LSU : GNT_IFU;
`else
  assign tie_gnt = GNT_LSU;
`endif

  assign sel_arvalid = (gnt_q == GNT_IFU) ? ifu_arvalid : lsu_arvalid;
  assign sel_rready  = (gnt_q == GNT_IFU) ? ifu_rready  : lsu_rready;

  // R payload is broadcast; only rvalid is steered by the grant
  assign ifu_rdata = out_rdata;
  assign ifu_rresp = out_rresp;
  assign ifu_rid   = out_rid;
  assign ifu_rlast = out_rlast;
  assign lsu_rdata = out_rdata;
  assign lsu_rresp = out_rresp;
  assign lsu_rid   = out_rid;
  assign lsu_rlast = out_rlast;

  // Write channels are a straight wire-through in every state
  assign out_awaddr  = lsu_awaddr;
  assign out_awid    = lsu_awid;
  assign out_awlen   = lsu_awlen;
  assign out_awsize  = lsu_awsize;
  assign out_awburst = lsu_awburst;
  assign out_awvalid = lsu_awvalid;
  assign lsu_awready = out_awready;
  assign out_wdata   = lsu_wdata;
  assign out_wstrb   = lsu_wstrb;
  assign out_wlast   = lsu_wlast;
  assign out_wvalid  = lsu_wvalid;
  assign lsu_wready  = out_wready;
  assign lsu_bresp   = out_bresp;
  assign lsu_bid     = out_bid;
  assign lsu_bvalid  = out_bvalid;
  assign out_bready  = lsu_bready;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      gnt_q   <= GNT_IFU;
      last_q  <= GNT_LSU;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Next state plus AR/R steering
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    out_araddr  = 32'h0;
    out_arid    = 4'h0;
    out_arlen   = 8'h0;
    out_arsize  = 3'h0;
    out_arburst = 2'h0;
    out_arvalid = 1'b0;
    out_rready  = 1'b0;
    ifu_arready = 1'b0;
    lsu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_rvalid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ifu_arvalid || lsu_arvalid) begin
          state_d = S_ADDR;
          if (ifu_arvalid && lsu_arvalid) gnt_d = tie_gnt;
          else if (lsu_arvalid)           gnt_d = GNT_LSU;
          else                            gnt_d = GNT_IFU;
        end
      end
      S_ADDR: begin
        if (gnt_q == GNT_IFU) begin
          out_araddr  = ifu_araddr;
          out_arid    = ifu_arid;
          out_arlen   = ifu_arlen;
          out_arsize  = ifu_arsize;
          out_arburst = ifu_arburst;
          ifu_arready = out_arready;
        end else begin
          out_araddr  = lsu_araddr;
          out_arid    = lsu_arid;
          out_arlen   = lsu_arlen;
          out_arsize  = lsu_arsize;
          out_arburst = lsu_arburst;
          lsu_arready = out_arready;
        end
        out_arvalid = sel_arvalid;
        if (sel_arvalid && out_arready) begin
          state_d = S_DATA;
          last_d  = gnt_q;
        end
      end
      S_DATA: begin
        out_rready = sel_rready;
        if (gnt_q == GNT_IFU) ifu_rvalid = out_rvalid;
        else                  lsu_rvalid = out_rvalid;
        if (out_rvalid && sel_rready && out_rlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
